comp_serializer: RTL and testbench
==================================

// Module: comp_serializer
// PURPOSE
//   Upstream feeder for the serial magnitude comparator (comp). Accepts two
//   parallel WIDTH-bit operands through a valid/ready handshake. Shifts them
//   out LSB-first, one bit pair per clock, on a/b, with framing strobes.
//   LSB-first order is required: comp's last-differing-bit-wins rule then
//   yields a correct magnitude result.
// PARAMETERS
//   WIDTH  8  operand width in bits; legal range >= 1
// PORTS
//   clk        in   1      single clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      a_word/b_word are valid
//   in_ready   out  1      block can accept a word pair (registered)
//   a_word     in   WIDTH  operand A, parallel
//   b_word     in   WIDTH  operand B, parallel
//   abort      in   1      synchronous abort of the frame in progress
//   a          out  1      serial bit of A; drives comp.a
//   b          out  1      serial bit of B; drives comp.b
//   bit_valid  out  1      a/b carry a live bit this cycle
//   last       out  1      current bit is the MSB (final bit of the frame)
//   done       out  1      one-cycle pulse after the final bit
//   frame_rst  out  1      only when COMP_SER_FRAME_SYNC_EN is defined
// BEHAVIOUR
//   Reset values: in_ready=1; a, b, bit_valid, last, done, frame_rst = 0;
//     state=IDLE; shift registers and counter cleared.
//   FSM states: IDLE -> (SYNC) -> SHIFT -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready, capture a_word/b_word, set
//     cnt=WIDTH-1 and in_ready=0. Next state is SHIFT, or SYNC if enabled.
//   SHIFT: each cycle a=sh_a[0], b=sh_b[0], bit_valid=1, last=(cnt==0).
//     Shift both registers right and decrement cnt.
//     At cnt==0, go to IDLE: done=1 and in_ready=1 in the following cycle.
//   Timing: accept at cycle 0; bits at cycles 1..WIDTH; last=1 at WIDTH;
//     done=1 at WIDTH+1.
//   done cycle is IDLE: a new word may be accepted in the same cycle.
//     Throughput is one frame per WIDTH+1 cycles.
//   a/b are forced to 0 whenever bit_valid=0; all outputs are registered.
//   in_valid while in_ready=0 is ignored; words are not queued.
//   abort (any non-IDLE state): next cycle state=IDLE, in_ready=1, with
//     bit_valid=0, last=0, done=0 (no done for an aborted frame).
//     abort in IDLE is a no-op; abort has priority over acceptance that cycle.
//   reset mid-frame: immediate return to reset values; partial frame lost.
//   WIDTH=1: a single SHIFT cycle with last=1.
//   cnt width is $clog2(WIDTH+1); no wrap-around is possible.
// CONFIGURATION
//   COMP_SER_FRAME_SYNC_EN defined:
//     - SYNC state inserted after accept; frame_rst=1 for exactly that cycle
//       (cycle 1), to clear the downstream comparator to EQUAL.
//     - Bits move to cycles 2..WIDTH+1; done at WIDTH+2.
//     - abort during SYNC behaves as abort in SHIFT.
//   Not defined: no frame_rst port and no SYNC state; timing as in BEHAVIOUR.
// STRUCTURE
//   Package comp_ser_pkg:
//     - FSM state localparams S_IDLE=2'd0, S_SYNC=2'd1, S_SHIFT=2'd2.
//     - Comparator result codes EQUAL=3'b001, GREATER=3'b010, LESS=3'b011.
//   Sub-module ser_shift_reg (WIDTH; load, shift, clear): instantiated
//     twice, once per operand. FSM and counter stay in the top module.
// TESTING (WIDTH=8, frame sync off unless stated; bench pairs block with comp)
//   1 a_word=8'hA5, b_word=8'h3C -> a = 1,0,1,0,0,1,0,1 on cycles 1..8;
//     last only at cycle 8; done at cycle 9; comp ends greater=1.
//   2 a_word=b_word=8'h5A after comp reset -> comp ends equal=1;
//     a==b on every bit_valid cycle.
//   3 in_valid held high with 3 word pairs -> accepts at cycles 0, 9, 18;
//     no bit gap beyond the done cycle; in_ready=0 during shifting.
//   4 reset asserted at cycle 4 of a frame -> all outputs 0 and in_ready=1
//     at once; next accepted word streams cleanly from its bit 0.
//   5 abort at cycle 5 -> bit_valid=0 next cycle, no done pulse; in_ready=1;
//     a new word is accepted the cycle after.
//   6 COMP_SER_FRAME_SYNC_EN defined, a=8'h01, b=8'h80, comp previously
//     GREATER -> frame_rst=1 at cycle 1; bits on cycles 2..9;
//     done at cycle 10; comp ends less=1.

Source files
------------

// File: rtl/comp_ser_pkg.sv
// Purpose: shared FSM encodings and comparator result codes for the comp serializer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package comp_ser_pkg;

    // Serializer FSM state encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SYNC  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    // Downstream serial comparator result codes
    localparam logic [2:0] EQUAL   = 3'b001;
    localparam logic [2:0] GREATER = 3'b010;
    localparam logic [2:0] LESS    = 3'b011;

endpackage

// File: rtl/ser_shift_reg.sv
// Purpose: one operand's LSB-first shifter with a registered serial output bit.
// Latency: load+shift together present d[0] the next cycle; each shift presents the next bit.
// Backpressure: none; the owning FSM decides every cycle whether a bit is emitted.
module ser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             ser
);

    // Bits not yet emitted; ser holds the bit on the wire this cycle
    logic [WIDTH-1:0] rest;

    // Load / shift / clear; ser falls back to 0 on any cycle without a shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rest <= '0;
            ser  <= 1'b0;
        end else if (clear) begin
            rest <= '0;
            ser  <= 1'b0;
        end else if (load) begin
            if (shift) begin
                ser  <= d[0];
                rest <= d >> 1;
            end else begin
                ser  <= 1'b0;
                rest <= d;
            end
        end else if (shift) begin
            ser  <= rest[0];
            rest <= rest >> 1;
        end else begin
            ser  <= 1'b0;
        end
    end

endmodule

// File: rtl/comp_serializer.sv
// Purpose: feeds a serial magnitude comparator; takes an operand pair by valid/ready, emits it LSB-first.
// Latency: accept at cycle 0, bits on cycles 1..WIDTH, done at WIDTH+1 (one cycle later with COMP_SER_FRAME_SYNC_EN).
// Backpressure: in_ready low for the whole frame; in_valid while not ready is ignored, nothing is queued.
// COMP_SER_FRAME_SYNC_EN: adds a SYNC cycle after accept that pulses frame_rst to clear the comparator.
module comp_serializer
    import comp_ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             last,
    output logic             done
`ifdef COMP_SER_FRAME_SYNC_EN
    ,
    output logic             frame_rst
`endif
);

    // Counter must hold WIDTH-1 and reach 0; it never wraps
    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;
    logic          sh_load;
    logic          sh_shift;
    logic          sh_clear;
    logic          in_ready_nxt;
    logic          bit_valid_nxt;
    logic          last_nxt;
    logic          done_nxt;
`ifdef COMP_SER_FRAME_SYNC_EN
    logic          frame_rst_nxt;
`endif

    // Abort wins over a handshake presented in the same cycle
    assign accept = in_valid && in_ready && !abort && (state == S_IDLE);

    // State, counter and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            bit_valid <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
`ifdef COMP_SER_FRAME_SYNC_EN
            frame_rst <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            in_ready  <= in_ready_nxt;
            bit_valid <= bit_valid_nxt;
            last      <= last_nxt;
            done      <= done_nxt;
`ifdef COMP_SER_FRAME_SYNC_EN
            frame_rst <= frame_rst_nxt;
`endif
        end
    end

    // Next state and counter: cnt counts down the bits still to emit after the current one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nxt = CNT_LOAD;
`ifdef COMP_SER_FRAME_SYNC_EN
                    state_nxt = S_SYNC;
`else
                    state_nxt = S_SHIFT;
`endif
                end
            end
            S_SYNC: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from where the FSM is heading
    always_comb begin
        in_ready_nxt  = (state_nxt == S_IDLE);
        bit_valid_nxt = (state_nxt == S_SHIFT);
        last_nxt      = (state_nxt == S_SHIFT) && (cnt_nxt == '0);
        done_nxt      = (state == S_SHIFT) && (cnt == '0) && !abort;
`ifdef COMP_SER_FRAME_SYNC_EN
        frame_rst_nxt = (state_nxt == S_SYNC);
`endif
        sh_load       = accept;
        sh_shift      = (state_nxt == S_SHIFT);
        sh_clear      = abort && (state != S_IDLE);
    end

    ser_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk   (clk),
        .reset (reset),
        .clear (sh_clear),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (a_word),
        .ser   (a)
    );

    ser_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk   (clk),
        .reset (reset),
        .clear (sh_clear),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (b_word),
        .ser   (b)
    );

endmodule

// File: tb/tb_comp_serializer.sv
// Purpose: directed bench for comp_serializer (WIDTH=8 plus a WIDTH=1 instance) with a reference serial comparator.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: exercises held in_valid, mid-frame reset and abort.
module tb_comp_serializer;
    import comp_ser_pkg::*;

`ifdef COMP_SER_FRAME_SYNC_EN
    localparam int SYNC_CYC = 1;
`else
    localparam int SYNC_CYC = 0;
`endif
    localparam int FRAME = 9 + SYNC_CYC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a_word = 8'h00;
    logic [7:0] b_word = 8'h00;
    logic       abort = 1'b0;
    logic       in_ready, a, b, bit_valid, last, done;

    logic       v1 = 1'b0;
    logic [0:0] aw1 = 1'b0;
    logic [0:0] bw1 = 1'b0;
    logic       rdy1, a1, b1, bv1, last1, done1;
`ifdef COMP_SER_FRAME_SYNC_EN
    logic       frame_rst, fr1;
`endif

    logic       comp_clr = 1'b1;
    logic [2:0] comp_res;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comp_serializer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_word(a_word), .b_word(b_word), .abort(abort),
        .a(a), .b(b), .bit_valid(bit_valid), .last(last), .done(done)
`ifdef COMP_SER_FRAME_SYNC_EN
        , .frame_rst(frame_rst)
`endif
    );

    comp_serializer #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1),
        .a_word(aw1), .b_word(bw1), .abort(abort),
        .a(a1), .b(b1), .bit_valid(bv1), .last(last1), .done(done1)
`ifdef COMP_SER_FRAME_SYNC_EN
        , .frame_rst(fr1)
`endif
    );

    // Reference serial comparator: last differing bit (LSB-first) decides
    always @(posedge clk) begin
        if (comp_clr) begin
            comp_res <= EQUAL;
`ifdef COMP_SER_FRAME_SYNC_EN
        end else if (frame_rst) begin
            comp_res <= EQUAL;
`endif
        end else if (bit_valid) begin
            if (a && !b)
                comp_res <= GREATER;
            else if (!a && b)
                comp_res <= LESS;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full frame from an idle cycle through the done cycle
    task automatic run_frame(input logic [7:0] wa, input logic [7:0] wb);
        check("start_ready", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b1;
        a_word   = wa;
        b_word   = wb;
        step();
        in_valid = 1'b0;
`ifdef COMP_SER_FRAME_SYNC_EN
        check("sync_frame_rst", {7'd0, frame_rst}, 8'd1);
        check("sync_bit_valid", {7'd0, bit_valid}, 8'd0);
        step();
`endif
        for (int i = 0; i < 8; i++) begin
            check("bit_a", {7'd0, a}, {7'd0, wa[i]});
            check("bit_b", {7'd0, b}, {7'd0, wb[i]});
            check("bit_valid", {7'd0, bit_valid}, 8'd1);
            check("bit_last", {7'd0, last}, {7'd0, (i == 7)});
            check("bit_ready", {7'd0, in_ready}, 8'd0);
            check("bit_done", {7'd0, done}, 8'd0);
`ifdef COMP_SER_FRAME_SYNC_EN
            check("bit_frame_rst", {7'd0, frame_rst}, 8'd0);
`endif
            step();
        end
        check("done_pulse", {7'd0, done}, 8'd1);
        check("done_bit_valid", {7'd0, bit_valid}, 8'd0);
        check("done_ready", {7'd0, in_ready}, 8'd1);
        check("done_a_zero", {7'd0, a}, 8'd0);
        check("done_last", {7'd0, last}, 8'd0);
    endtask

    logic [7:0] pa [3];
    logic [7:0] pb [3];
    int         nacc;
    logic       acc;

    initial begin
        pa[0] = 8'h11; pa[1] = 8'h96; pa[2] = 8'hE7;
        pb[0] = 8'h22; pb[1] = 8'h69; pb[2] = 8'h18;

        // Reset values
        step();
        step();
        check("rst_ready", {7'd0, in_ready}, 8'd1);
        check("rst_bit_valid", {7'd0, bit_valid}, 8'd0);
        check("rst_ab", {6'd0, a, b}, 8'd0);
        check("rst_last_done", {6'd0, last, done}, 8'd0);
        check("rst_w1_ready", {7'd0, rdy1}, 8'd1);
`ifdef COMP_SER_FRAME_SYNC_EN
        check("rst_frame_rst", {7'd0, frame_rst}, 8'd0);
`endif
        reset = 1'b0;
        step();
        comp_clr = 1'b0;

        // 1: A5 vs 3C, comparator ends GREATER
        run_frame(8'hA5, 8'h3C);
        check("t1_comp", {5'd0, comp_res}, {5'd0, GREATER});

        // 2: equal operands after comparator clear
        comp_clr = 1'b1;
        step();
        comp_clr = 1'b0;
        run_frame(8'h5A, 8'h5A);
        check("t2_comp", {5'd0, comp_res}, {5'd0, EQUAL});

        // 3: in_valid held high across three frames, back to back
        nacc     = 0;
        in_valid = 1'b1;
        a_word   = pa[0];
        b_word   = pb[0];
        for (int c = 0; c < 3 * FRAME; c++) begin
            check("t3_ready", {7'd0, in_ready}, {7'd0, ((c % FRAME) == 0)});
            check("t3_bit_valid", {7'd0, bit_valid}, {7'd0, ((c % FRAME) > SYNC_CYC)});
            acc = in_ready && in_valid;
            if (acc) nacc++;
            step();
            if (acc) begin
                if (nacc < 3) begin
                    a_word = pa[nacc];
                    b_word = pb[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("t3_accepts", nacc[7:0], 8'd3);
        check("t3_final_done", {7'd0, done}, 8'd1);

        // 4: reset at cycle 4 of a frame
        in_valid = 1'b1;
        a_word   = 8'hA5;
        b_word   = 8'h3C;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        check("t4_ready", {7'd0, in_ready}, 8'd1);
        check("t4_bit_valid", {7'd0, bit_valid}, 8'd0);
        check("t4_ab", {6'd0, a, b}, 8'd0);
        check("t4_last_done", {6'd0, last, done}, 8'd0);
        step();
        reset = 1'b0;
        step();
        run_frame(8'h0F, 8'hF0);

        // 5: abort at cycle 5, new word accepted the cycle after
        in_valid = 1'b1;
        a_word   = 8'hFF;
        b_word   = 8'h00;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_bit_valid", {7'd0, bit_valid}, 8'd0);
        check("t5_last", {7'd0, last}, 8'd0);
        check("t5_no_done", {7'd0, done}, 8'd0);
        check("t5_a_zero", {7'd0, a}, 8'd0);
        run_frame(8'hC3, 8'h3C);

        // 6: GREATER then 01 vs 80 ends LESS
        comp_clr = 1'b1;
        step();
        comp_clr = 1'b0;
        run_frame(8'hA5, 8'h3C);
        check("t6_comp_pre", {5'd0, comp_res}, {5'd0, GREATER});
        run_frame(8'h01, 8'h80);
        check("t6_comp", {5'd0, comp_res}, {5'd0, LESS});

        // 7: WIDTH=1 frame is one SHIFT cycle with last
        check("w1_idle_ready", {7'd0, rdy1}, 8'd1);
        v1  = 1'b1;
        aw1 = 1'b1;
        bw1 = 1'b0;
        step();
        v1 = 1'b0;
`ifdef COMP_SER_FRAME_SYNC_EN
        check("w1_frame_rst", {7'd0, fr1}, 8'd1);
        step();
`endif
        check("w1_bit_valid", {7'd0, bv1}, 8'd1);
        check("w1_last", {7'd0, last1}, 8'd1);
        check("w1_ab", {6'd0, a1, b1}, 8'd2);
        check("w1_busy", {7'd0, rdy1}, 8'd0);
        check("w1_no_done", {7'd0, done1}, 8'd0);
        step();
        check("w1_done", {7'd0, done1}, 8'd1);
        check("w1_end_bit_valid", {7'd0, bv1}, 8'd0);
        check("w1_ready", {7'd0, rdy1}, 8'd1);
        check("w1_end_last", {7'd0, last1}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
